// File: rtl/lpfull_decimate2.sv
// rtl/lpfull_decimate2.sv - decimate-by-2 of the lowpass sample stream, pairing two half-words into one output word
//
// Optional saturating requantizer and clamp counter: define LPFULL_DECIMATE2_SAT_EN.
// With the macro undefined, each kept sample keeps only its low OBITS bits (two's-complement wrap),
// and sat_cnt_o is tied to zero.

module lpfull_decimate2 #(
    parameter int NSAMP = 8,
    parameter int IBITS = 13,
    parameter int OBITS = 12
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NSAMP-1:0][IBITS-1:0]     dat_i,
    input  logic                            sync_i,
    output logic [NSAMP-1:0][OBITS-1:0]     dat_o,
    output logic                            valid_o,
    output logic [15:0]                     sat_cnt_o
);

    localparam int HALF = NSAMP / 2;

    // Odd samples are discarded by design, and the wrap mode ignores the top bits.
    logic unused_inputs;
    assign unused_inputs = ^dat_i;

    logic [HALF-1:0][OBITS-1:0] h;
    logic [HALF-1:0][OBITS-1:0] lo_q;
    logic                       phase;
    logic signed [IBITS-1:0]    samp;

`ifdef LPFULL_DECIMATE2_SAT_EN
    localparam logic signed [IBITS-1:0] SMAX = IBITS'((2 ** (OBITS - 1)) - 1);
    localparam logic signed [IBITS-1:0] SMIN = IBITS'(-(2 ** (OBITS - 1)));
    logic        clamp_any;
    logic [15:0] sat_cnt_q;
`endif

    // Keep the even samples of this cycle and requantize them into half-word H.
    always_comb begin
        h    = '0;
        samp = '0;
`ifdef LPFULL_DECIMATE2_SAT_EN
        clamp_any = 1'b0;
`endif
        for (int k = 0; k < HALF; k++) begin
            samp = dat_i[2 * k];
`ifdef LPFULL_DECIMATE2_SAT_EN
            if (samp > SMAX) begin
                h[k]      = SMAX[OBITS-1:0];
                clamp_any = 1'b1;
            end else if (samp < SMIN) begin
                h[k]      = SMIN[OBITS-1:0];
                clamp_any = 1'b1;
            end else begin
                h[k] = samp[OBITS-1:0];
            end
`else
            h[k] = samp[OBITS-1:0];
`endif
        end
    end

    // Phase tracking: hold the first half, emit the full word when the second half arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase   <= 1'b0;
            lo_q    <= '0;
            dat_o   <= '0;
            valid_o <= 1'b0;
        end else if (!phase || sync_i) begin
            // A sync in phase 1 drops the pending half and restarts with the current one.
            lo_q    <= h;
            phase   <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            dat_o   <= {h, lo_q};
            phase   <= 1'b0;
            valid_o <= 1'b1;
        end
    end

`ifdef LPFULL_DECIMATE2_SAT_EN
    // Count cycles in which any kept sample was clamped; sticks at the ceiling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_cnt_q <= '0;
        end else if (clamp_any && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    assign sat_cnt_o = 16'd0;
`endif

endmodule

// File: doc/lpfull_decimate2.md
LPFULL_DECIMATE2 -- requirements
Module: lpfull_decimate2

Interface
REQ-001 SHALL have parameter NSAMP, default 8, samples per clock on input and output.
REQ-002 SHALL have parameter IBITS, default 13, signed input sample width (lowpass output).
REQ-003 SHALL have parameter OBITS, default 12, signed output sample width.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port dat_i, input, [NSAMP-1:0][IBITS-1:0], lowpass samples; index 0 is oldest in time.
REQ-007 SHALL have port sync_i, input, 1 bit, phase realign; the current dat_i becomes the first half of an output word.
REQ-008 SHALL have port dat_o, output, [NSAMP-1:0][OBITS-1:0], decimated samples, registered; index 0 is oldest.
REQ-009 SHALL have port valid_o, output, 1 bit, one-cycle strobe; dat_o is new on the cycle it is high.
REQ-010 SHALL have port sat_cnt_o, output, 16 bits, count of saturating cycles.

Function
REQ-011 SHALL form half-word H each cycle from dat_i indices 0,2,4,6 (decimate by 2, even samples kept, odd discarded).
REQ-012 SHALL requantize each kept IBITS sample to OBITS with no scaling: LSB weight preserved, conversion per REQ-031/032.
REQ-013 SHALL hold a 1-bit phase register; phase 0 means "expecting first half", phase 1 means "expecting second half".
REQ-014 SHALL, at an edge with phase 0 or sync_i high, load lo_q <= H, set phase <= 1 and drive valid_o <= 0.
REQ-015 SHALL, at an edge with phase 1 and sync_i low, load dat_o[3:0] <= lo_q and dat_o[7:4] <= H, set phase <= 0 and drive valid_o <= 1.
REQ-016 SHALL give a latency of one edge: dat_o and valid_o update on the same edge that captures the second half.
REQ-017 SHALL, when sync_i is high during phase 1, discard the pending lo_q, emit no word and restart with the current H as the first half.
REQ-018 SHALL hold dat_o stable between valid_o strobes.
REQ-019 SHALL, with input continuous and sync_i low, strobe valid_o on exactly every second cycle.
REQ-020 SHALL keep index order in time: dat_o[k] equals requantized dat_i[2k] of the first cycle for k<4, and requantized dat_i[2(k-4)] of the second cycle for k>=4.
REQ-021 SHALL, with SAT_EN defined, increment sat_cnt_o by 1 on each edge (rst_i low) where any kept sample of H was clamped, regardless of phase.
REQ-022 SHALL stop sat_cnt_o at 16'hFFFF; it does not wrap.

Reset
REQ-023 SHALL, on an edge with rst_i high, set phase to 0, lo_q to 0, dat_o to 0, valid_o to 0 and sat_cnt_o to 0.
REQ-024 SHALL give reset priority over sync_i and over data capture.
REQ-025 SHALL, on a reset asserted mid-word (phase 1), drop the pending half-word and emit no valid_o for it.
REQ-026 SHALL treat the first cycle after reset deassertion as a first half (phase 0).

Configuration
REQ-030 SHALL select the requantization mode with macro LPFULL_DECIMATE2_SAT_EN.
REQ-031 SHALL, with LPFULL_DECIMATE2_SAT_EN defined, clamp inputs above 2047 to 2047 and below -2048 to -2048, and make sat_cnt_o active.
REQ-032 SHALL, with LPFULL_DECIMATE2_SAT_EN undefined, take the low OBITS bits (two's-complement wrap), tie sat_cnt_o to 0 and implement no counter logic.

Verification
REQ-040 SHALL cover reset then ramp: dat_i[j] = 10*j + 100*cycle -> valid_o every second cycle; first word dat_o = {0,20,40,60,100,120,140,160} (index 0 first).
REQ-041 SHALL cover saturation with SAT_EN: dat_i[0] = 3000, dat_i[2] = -3000, all others 0 -> dat_o halves hold 2047 and -2048; sat_cnt_o increments by 1 per such cycle.
REQ-042 SHALL cover wrap without SAT_EN: dat_i[0] = 2048 -> output -2048; sat_cnt_o remains 0.
REQ-043 SHALL cover sync during phase 1: input A on cycle 1, sync_i high with B on cycle 2, C on cycle 3 -> no strobe after cycle 2, strobe after cycle 3 with word {B,C}; A never appears.
REQ-044 SHALL cover reset mid-word: A in phase 0, then rst_i high one cycle, then B, C -> word {B,C}; dat_o is 0 until then.
REQ-045 SHALL cover counter ceiling: force 70000 consecutive clamped cycles -> sat_cnt_o holds 16'hFFFF.
